dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 38 +++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and the data memory
// responder. The initiator drives the request fields; the responder drives
// req_ready and the single-cycle response strobe with its payload.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [3:0]  req_size;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_size,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_size,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed data memory responder. Accepts one load or store at a time,
// waits a fixed number of cycles, then issues a one-cycle response. Illegal
// requests (bad size, misaligned, or out of range) complete with an error
// and never touch storage. Stores commit on the edge that ends the response.
module dmem_responder #(
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic          accept;

  // Request captured on acceptance and held until the response completes.
  logic          lat_write;
  logic [63:0]   lat_addr;
  logic [3:0]    lat_size;
  logic [63:0]   lat_wdata;

  // Legality of the captured request.
  logic          size_ok;
  logic          align_ok;
  logic          range_ok;
  logic          legal;
  logic [64:0]   end_addr;
  logic [AW-1:0] base;

  logic [7:0]    mem [DEPTH_BYTES];

  assign accept = bus.req_valid && bus.req_ready;
  assign base   = lat_addr[AW-1:0];

  // Legality is judged on the full 64-bit address; the 65-bit sum keeps a
  // request near the top of the address space from wrapping back into range.
  assign size_ok  = lat_size inside {4'd1, 4'd2, 4'd4, 4'd8};
  assign align_ok = (lat_addr & {60'd0, lat_size - 4'd1}) == 64'd0;
  assign end_addr = {1'b0, lat_addr} + {61'd0, lat_size};
  assign range_ok = end_addr <= 65'(DEPTH_BYTES);
  assign legal    = size_ok && align_ok && range_ok;

  // State register and wait counter.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order processes are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: IDLE -> WAIT (or RESP when there are no wait cycles),
  // WAIT counts down and leaves on count 1, RESP always lasts one cycle.
  // NOTE: every signal gets a default at the top of a combinational block so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Outputs: ready only in IDLE, response payload only in RESP. Both are
  // masked by rst so a reset arriving mid-operation never shows a response.
  always_comb begin
    bus.req_ready  = (state == IDLE) && !rst;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = 64'd0;
    if ((state == RESP) && !rst) begin
      bus.resp_valid = 1'b1;
      if (!legal) begin
        bus.resp_err = 1'b1;
      end else if (!lat_write) begin
        for (int k = 0; k < 8; k++) begin
          if (4'(k) < lat_size) begin
            bus.resp_rdata[8*k +: 8] = mem[base + AW'(k)];
          end
        end
      end
    end
  end

  // Capture the request fields on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_addr  <= 64'd0;
      lat_size  <= 4'd0;
      lat_wdata <= 64'd0;
    end else if (accept) begin
      lat_write <= bus.req_write;
      lat_addr  <= bus.req_addr;
      lat_size  <= bus.req_size;
      lat_wdata <= bus.req_wdata;
    end
  end

  // Byte storage: cleared by reset, written by a legal store as RESP ends.
  // NOTE: reset must clear every byte, so storage is a flop array with a
  // reset branch rather than an unreset RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= 8'd0;
      end
    end else if ((state == RESP) && legal && lat_write) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < lat_size) begin
          mem[base + AW'(k)] <= lat_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule
